uart_transmitter: RTL
=====================

# uart_transmitter

Serial transmit path between the Riscv151 core's memory-mapped UART TX data register and the `FPGA_SERIAL_TX` pin. The block accepts bytes from the CPU over a valid/ready handshake and buffers them in a small FIFO. It serialises each byte as an 8N1 frame at a fixed baud rate derived from the CPU clock. The CPU polls `data_in_ready` through the UART control register before each store to the TX data address.

## Interface
- `CLOCK_FREQ`, 50_000_000, CPU clock frequency in Hz.
- `BAUD_RATE`, 115_200, line rate in bits/s.
- `FIFO_DEPTH`, 8, byte buffer depth; must be a power of two and at least 2.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input 8: byte to transmit.
- `data_in_valid` input 1: CPU presents `data_in`.
- `data_in_ready` output 1: FIFO can accept a byte this cycle.
- `tx_idle` output 1: FIFO is empty and no frame is in flight.
- `serial_out` output 1: UART line; idles high.

## Operation
- `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE`, using integer (truncating) division. At the defaults this is 434. The symbol counter is `$clog2(SYMBOL_EDGE_TIME)` bits wide.
- Push: a byte is written to the FIFO at a rising edge where `data_in_valid && data_in_ready`.
- `data_in_ready = !full && !rst`. It is derived from registered FIFO state only, so a pop in the same cycle does not free a slot for that cycle's push.
- Frame format: 1 start bit (0), then 8 data bits sent LSB first, then 1 stop bit (1). A frame is 10 symbols.
- FSM states:
  - IDLE: `serial_out` is 1. If the FIFO is non-empty, pop the head into `tx_shift`, clear the symbol counter, and go to START.
  - START: `serial_out` is 0 for SYMBOL_EDGE_TIME cycles, then go to DATA with bit index 0.
  - DATA: `serial_out = tx_shift[bit_idx]` for SYMBOL_EDGE_TIME cycles. After bit 7, go to STOP.
  - STOP: `serial_out` is 1 for SYMBOL_EDGE_TIME cycles. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- `serial_out` is driven from a register and never from combinational logic.
- `tx_idle = (state == IDLE) && empty`.
- FIFO full: pushes stall. No byte is dropped or overwritten.
- FIFO empty: no pop occurs, and the FSM stays in IDLE.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap modulo 2×depth. Full and empty are decided by comparing the MSBs.
- Reset at any point, including mid-frame, has the following effect at the next edge:
  - FSM returns to IDLE.
  - FIFO is emptied.
  - `serial_out` goes to 1.
  - Counters are cleared.
  - The partially sent byte is discarded.

## Timing
- Reset values:
  - `serial_out` = 1.
  - `data_in_ready` = 0 while `rst` is high, and 1 on the first cycle after `rst` falls.
  - `tx_idle` = 1.
- Latency: for a handshake at edge E into an empty, idle block, the FSM pops at edge E+1 and `serial_out` falls immediately after E+1.
- Each symbol lasts exactly SYMBOL_EDGE_TIME cycles, so a frame lasts exactly 10×SYMBOL_EDGE_TIME cycles.
- `tx_idle` rises on the edge that ends the final STOP symbol.
- Throughput: one push per cycle while `data_in_ready` is high. Back-to-back frames are contiguous on the line.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE/START/DATA/STOP).
  - Frame constants: `DATA_BITS = 8`, `FRAME_SYMBOLS = 10`.
  - The SYMBOL_EDGE_TIME function, reused by `uart_receiver`.
- Sub-module `sync_fifo`:
  - Parameters: WIDTH and DEPTH.
  - Ports: `clk`, `rst`, `wr_en`, `din`, `full`, `rd_en`, `dout`, `empty`.
  - Read data is registered and available after the `rd_en` edge.
  - Reusable for the RX path.
- The top level holds the FSM, the symbol counter, the bit index, and the `tx_shift` register.

## Test plan
- Single byte: after reset, push 0xA5. `serial_out` must be 0,1,0,1,0,0,1,0,1,1, with each symbol held exactly 434 cycles. The start bit falls one cycle after the handshake edge. `tx_idle` must return to 1 exactly 4340 cycles after the start bit falls.
- Burst: hold `data_in_valid` high while presenting 12 bytes 0x00..0x0B. `data_in_ready` must drop once 8 entries are occupied. All 12 bytes must appear in order with no idle gap between frames, over 12×4340 cycles.
- Full-with-pop: with the FIFO full and a pop occurring, `data_in_ready` must stay 0 in that cycle and rise on the following cycle. The total count of accepted bytes must equal the count of transmitted bytes.
- Reset mid-frame: assert `rst` during data bit 3 of 0x3C with 4 bytes queued. The next cycle must show `serial_out` = 1, `tx_idle` = 1, and FIFO empty. A push of 0x81 after reset must produce a single clean frame.
- Ready during reset: while `rst` is held for 30 cycles with `data_in_valid` = 1, `data_in_ready` must stay 0 and no frame may start afterward.
- Non-integer divisor: with CLOCK_FREQ = 1_000_000 and BAUD_RATE = 300_000, symbols must last exactly 3 cycles. Sending 0xFF must yield the sequence 0, eight 1s, 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX FSM encoding, frame constants and the baud divisor.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int DATA_BITS     = 8;
    localparam int FRAME_SYMBOLS = 10;

    // Cycles per symbol; truncating division, so the line runs slightly fast.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; pointers carry an extra wrap bit.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) begin
                dout   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: CPU bytes are buffered in a FIFO and shifted out LSB first.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       tx_idle,
    output logic       serial_out
);
    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_e      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       tx_shift;
    logic [7:0]       shift_src;
    logic             pop, pop_d;
    logic             so_n;
    logic             sym_end;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;

    assign data_in_ready = !fifo_full && !rst;
    assign tx_idle       = (state == IDLE) && fifo_empty;
    assign sym_end       = (cnt == CNT_LAST);
    // FIFO read data lands one cycle after the pop; bypass it until tx_shift captures it.
    assign shift_src     = pop_d ? fifo_dout : tx_shift;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (data_in_valid && data_in_ready),
        .din   (data_in),
        .full  (fifo_full),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: if (sym_end) begin
                cnt_n   = '0;
                bit_n   = '0;
                state_n = DATA;
            end
            DATA: if (sym_end) begin
                cnt_n = '0;
                if (bit_idx == BIT_LAST) state_n = STOP;
                else                     bit_n   = bit_idx + 1'b1;
            end
            STOP: if (sym_end) begin
                cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // The line level is registered from the next state so edges align with state changes.
        so_n = 1'b1;
        case (state_n)
            START:   so_n = 1'b0;
            DATA:    so_n = shift_src[bit_n];
            default: so_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            tx_shift   <= '0;
            pop_d      <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            pop_d      <= pop;
            serial_out <= so_n;
            if (pop_d)
                tx_shift <= fifo_dout;
        end
    end
endmodule
